// File: rtl/lbist_pkg.sv
// lbist_pkg: shared types and constants for the LBIST signature path.
//   LBIST_W          signature / pattern width
//   LBIST_LFSR_POLY  default LFSR feedback tap mask (x^8+x^6+x^5+x^4+1)
//   LBIST_MISR_POLY  default MISR feedback tap mask
//   lbist_state_e    run-sequencer FSM states
//   lbist_fix_seed   maps an all-zero seed to 1 so the LFSR cannot lock up
package lbist_pkg;

  localparam int unsigned LBIST_W = 8;

  localparam logic [LBIST_W-1:0] LBIST_LFSR_POLY = 8'hB8;
  localparam logic [LBIST_W-1:0] LBIST_MISR_POLY = 8'hB8;

  typedef enum logic [1:0] {
    StIdle,
    StSeed,
    StRun,
    StDone
  } lbist_state_e;

  // An all-zero LFSR state is a fixed point, so it is never loaded.
  function automatic logic [LBIST_W-1:0] lbist_fix_seed(input logic [LBIST_W-1:0] seed);
    return (seed == '0) ? LBIST_W'(1) : seed;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// lbist_misr: LBIST_W-bit shift register with polynomial feedback and a parallel data input.
// Used both as the response compactor (MISR) and, with data_i tied to zero, as the LFSR.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, clears the register
//   load_i      load load_val_i (has priority over en_i)
//   load_val_i  value to load
//   en_i        advance one step: {q[W-2:0], ^(q & Poly)} ^ data_i
//   data_i      data folded into the register on each step
//   sig_o       register contents
module lbist_misr
  import lbist_pkg::*;
#(
  parameter logic [LBIST_W-1:0] Poly = LBIST_MISR_POLY
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [LBIST_W-1:0] load_val_i,
  input  logic               en_i,
  input  logic [LBIST_W-1:0] data_i,
  output logic [LBIST_W-1:0] sig_o
);

  logic [LBIST_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = load_val_i;
    end else if (en_i) begin
      sig_d = {sig_q[LBIST_W-2:0], ^(sig_q & Poly)} ^ data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/lbist_sig_gen.sv
// lbist_sig_gen: LBIST pattern source (LFSR) and response compactor (MISR) with a
// START/BUSY/SIG_VALID run sequencer. A run loads the seed, applies PATTERNS vectors on
// cut_in_o while absorbing cut_out_i, then pulses sig_valid_o with the signature on
// sig_out_o next to the golden value on sig_in_o.
// Optional feature: define LBIST_XMASK_EN to add x_mask_i; masked response bits are
// forced to zero before absorption.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      run request, sampled only in idle or done
//   cut_out_i    CUT response to the current cut_in_o
//   x_mask_i     (LBIST_XMASK_EN only) response bits to ignore
//   cut_in_o     current test pattern (LFSR register)
//   sig_in_o     golden signature (GOLDEN)
//   sig_out_o    MISR register
//   sig_valid_o  one-cycle pulse when sig_out_o holds the final signature
//   busy_o       high while seeding or running
//   pat_cnt_o    vectors absorbed in the current run
module lbist_sig_gen
  import lbist_pkg::*;
#(
  parameter int unsigned        PATTERNS  = 255,
  parameter logic [LBIST_W-1:0] SEED      = 8'hA5,
  parameter logic [LBIST_W-1:0] LFSR_POLY = LBIST_LFSR_POLY,
  parameter logic [LBIST_W-1:0] MISR_POLY = LBIST_MISR_POLY,
  parameter logic [LBIST_W-1:0] GOLDEN    = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [LBIST_W-1:0] cut_out_i,
`ifdef LBIST_XMASK_EN
  input  logic [LBIST_W-1:0] x_mask_i,
`endif
  output logic [LBIST_W-1:0] cut_in_o,
  output logic [LBIST_W-1:0] sig_in_o,
  output logic [LBIST_W-1:0] sig_out_o,
  output logic               sig_valid_o,
  output logic               busy_o,
  output logic [LBIST_W-1:0] pat_cnt_o
);

  localparam logic [LBIST_W-1:0] SeedVal = lbist_fix_seed(SEED);
  localparam logic [LBIST_W-1:0] LastCnt = LBIST_W'(PATTERNS - 1);

  lbist_state_e       state_q;
  logic [LBIST_W-1:0] pat_cnt_q;
  logic               sig_valid_q;
  logic               busy_q;

  logic               seq_load;
  logic               seq_step;
  logic [LBIST_W-1:0] misr_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pat_cnt_q   <= '0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sig_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSeed;
            busy_q  <= 1'b1;
          end
        end
        StSeed: begin
          state_q   <= StRun;
          pat_cnt_q <= '0;
        end
        StRun: begin
          pat_cnt_q <= pat_cnt_q + LBIST_W'(1);
          if (pat_cnt_q == LastCnt) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (start_i) begin
            state_q <= StSeed;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Both registers load at the end of the seed cycle so the first run cycle
  // presents the seed pattern with an empty signature.
  assign seq_load = (state_q == StSeed);
  assign seq_step = (state_q == StRun);

`ifdef LBIST_XMASK_EN
  assign misr_data = cut_out_i & ~x_mask_i;
`else
  assign misr_data = cut_out_i;
`endif

  lbist_misr #(
    .Poly(LFSR_POLY)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (seq_load),
    .load_val_i(SeedVal),
    .en_i      (seq_step),
    .data_i    ('0),
    .sig_o     (cut_in_o)
  );

  lbist_misr #(
    .Poly(MISR_POLY)
  ) u_misr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (seq_load),
    .load_val_i('0),
    .en_i      (seq_step),
    .data_i    (misr_data),
    .sig_o     (sig_out_o)
  );

  assign sig_in_o    = GOLDEN;
  assign sig_valid_o = sig_valid_q;
  assign busy_o      = busy_q;
  assign pat_cnt_o   = pat_cnt_q;

endmodule
